// File: rtl/pipe_mux_tree_if.sv
// pipe_mux_tree_if -- handshake bundle for the pipelined N:1 mux tree.
//
// Signals (N = 2**SEL_W):
//   flush      producer -> mux   synchronous clear of all in-flight items
//   in_valid   producer -> mux   din/sel are valid this cycle
//   in_ready   mux -> producer   mux accepts the input this cycle
//   sel        producer -> mux   channel index, SEL_W bits
//   din        producer -> mux   N*WIDTH flattened inputs, channel k = din[k*WIDTH +: WIDTH]
//   out_valid  mux -> consumer   dout/out_sel are valid
//   out_ready  consumer -> mux   consumer accepts dout this cycle
//   dout       mux -> consumer   selected channel data
//   out_sel    mux -> consumer   select value that produced dout
//
// master: the side that feeds inputs and consumes results.
// slave:  the mux itself.
interface pipe_mux_tree_if #(
    parameter int WIDTH = 32,
    parameter int SEL_W = 3
);
    localparam int N = 1 << SEL_W;

    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic [SEL_W-1:0]     sel;
    logic [N*WIDTH-1:0]   din;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     dout;
    logic [SEL_W-1:0]     out_sel;

    modport master (
        output flush, in_valid, sel, din, out_ready,
        input  in_ready, out_valid, dout, out_sel
    );

    modport slave (
        input  flush, in_valid, sel, din, out_ready,
        output in_ready, out_valid, dout, out_sel
    );
endinterface

// File: rtl/pipe_mux_tree.sv
// pipe_mux_tree -- parametrised N:1 mux (N = 2**SEL_W) built as a binary tree
// of 2:1 levels with a register stage after every level. Depth = SEL_W.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (clears valids, data and selects)
//   bus    pipe_mux_tree_if.slave: flush, in_valid/in_ready, sel, din,
//          out_valid/out_ready, dout, out_sel
//
// Level i steers with sel bit i (LSB first); the full select travels down the
// pipe alongside the data so out_sel can attribute each result. The whole
// pipe advances together (global stall, bubbles are not collapsed).

// One tree node: 2:1 mux followed by its stage register.
module pipe_mux_tree_node #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             s,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  q <= '0;
        else if (en) q <= s ? b : a;
    end
endmodule

module pipe_mux_tree #(
    parameter int WIDTH = 32,
    parameter int SEL_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    pipe_mux_tree_if.slave   bus
);
    localparam int N = 1 << SEL_W;

    logic [SEL_W-1:0]            vld_pipe;
    logic [SEL_W-1:0][SEL_W-1:0] sel_q;
    // All tree nodes, level by level: level i starts at N - (N >> i)
    // and holds N >> (i+1) entries. The root is the last entry.
    logic [N-2:0][WIDTH-1:0]     node_q;
    logic                        adv;

    // Depends only on the output valid register and out_ready, never on in_valid.
    assign adv          = !vld_pipe[SEL_W-1] || bus.out_ready;
    assign bus.in_ready = adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            sel_q    <= '0;
        end else begin
            // Select echo is a data register: it loads on adv even during flush.
            if (adv) begin
                sel_q[0] <= bus.sel;
                for (int i = 1; i < SEL_W; i++) sel_q[i] <= sel_q[i-1];
            end
            // flush wins over adv and also drops the input offered this cycle.
            if (bus.flush) begin
                vld_pipe <= '0;
            end else if (adv) begin
                vld_pipe[0] <= bus.in_valid;
                for (int i = 1; i < SEL_W; i++) vld_pipe[i] <= vld_pipe[i-1];
            end
        end
    end

    for (genvar i = 0; i < SEL_W; i++) begin : g_lvl
        localparam int M    = N >> (i + 1);
        localparam int OFF  = N - (N >> i);
        localparam int OFFP = OFF - 2 * M;   // start of previous level
        for (genvar j = 0; j < M; j++) begin : g_node
            logic [WIDTH-1:0] a, b;
            logic             s;
            if (i == 0) begin : g_in
                assign a = bus.din[(2*j)*WIDTH   +: WIDTH];
                assign b = bus.din[(2*j+1)*WIDTH +: WIDTH];
                assign s = bus.sel[0];
            end else begin : g_mid
                // Select comes from the echo registered alongside the previous level.
                assign a = node_q[OFFP + 2*j];
                assign b = node_q[OFFP + 2*j + 1];
                assign s = sel_q[i-1][i];
            end
            pipe_mux_tree_node #(.WIDTH(WIDTH)) u_node (
                .clk   (clk),
                .rst_n (rst_n),
                .en    (adv),
                .s     (s),
                .a     (a),
                .b     (b),
                .q     (node_q[OFF + j])
            );
        end
    end

    assign bus.out_valid = vld_pipe[SEL_W-1];
    assign bus.dout      = node_q[N-2];
    assign bus.out_sel   = sel_q[SEL_W-1];
endmodule

// File: doc/pipe_mux_tree.md
Name: pipe_mux_tree

Overview:
- Parametrised, pipelined N:1 multiplexer built as a binary tree of 2:1 mux levels, with one register stage after every level.
- Sits in datapath wide-select paths (writeback/forwarding source select, CSR read select), where a flat wide mux would limit Fmax.
- Carries a valid/ready handshake, a global stall, a synchronous flush and an echo of the chosen select, so downstream logic can attribute each result to its source.

Parameters:
- WIDTH, 32, data bits per channel (>=1).
- SEL_W, 3, select width; channel count N = 2**SEL_W; pipeline depth = SEL_W (legal range 1..6).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous; clears all stage valids.
- in_valid  in  1  din/sel are valid this cycle.
- in_ready  out  1  block accepts in this cycle.
- sel  in  SEL_W  channel index.
- din  in  N*WIDTH  flattened inputs; channel k = din[k*WIDTH +: WIDTH].
- out_valid  out  1  dout/out_sel are valid.
- out_ready  in  1  consumer accepts dout this cycle.
- dout  out  WIDTH  selected channel data.
- out_sel  out  SEL_W  select value that produced dout.

Behaviour:
- Tree structure:
  - Level i (i = 0..SEL_W-1) pairs adjacent entries, using sel bit i (LSB first).
  - sel[i]=1 picks the odd (upper) entry; sel[i]=0 picks the even (lower) entry.
  - Level i output has N/2**(i+1) entries.
- Stage registers:
  - Stage i holds the level-i output entries, a valid bit, and the full SEL_W select (echoed, not consumed).
  - Stage SEL_W-1 drives dout, out_sel and out_valid.
- Advance:
  - adv = !out_valid || out_ready.
  - When adv=1, every stage loads from the previous stage; stage 0 loads from din/sel/in_valid.
  - When adv=0, all stages hold, bubbles included (global stall; no bubble collapse).
- in_ready = adv. This is combinational from out_ready and the out_valid register, with no path from in_valid.
- Transfers:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Latency: an input accepted at edge t produces out_valid at edge t+SEL_W-1, i.e. visible in the SEL_W-th cycle after acceptance, provided adv=1 throughout. Each stall cycle adds one cycle.
- Throughput: one result per cycle while out_ready=1.
- Data registers may load when their stage valid is 0, but dout is meaningful only while out_valid=1.
- Reset (rst_n=0, asynchronous):
  - All stage valids are 0; all data and select registers are 0.
  - Hence out_valid=0, dout=0, out_sel=0, and in_ready=1 once reset is released.
- Flush:
  - On a clock edge with flush=1, all valids clear to 0, regardless of stall.
  - An input presented in that cycle is discarded, even though in_ready may be 1.
  - Data registers are not cleared.
- Reset mid-operation: in-flight items are lost with no output; the first accepted input after release follows normal latency.
- Simultaneous events:
  - flush has priority over adv.
  - out_ready=1 together with in_valid=1 on a full pipeline both transfers out and accepts in, in the same cycle.
- sel is a full SEL_W value; every value is legal (no out-of-range case, since N = 2**SEL_W).
- No combinational path from din or sel to any output.

Test Plan:
- Reset/idle: rst_n=0 for 2 cycles with random inputs -> out_valid=0, dout=0, out_sel=0, in_ready=1; after release with in_valid=0 for 10 cycles -> out_valid stays 0.
- Sweep (WIDTH=8, SEL_W=3): din channel k = 8'h10+k; sel=0..7 on consecutive cycles, out_ready=1 -> out_valid first rises in the 3rd cycle after the first accept; dout = 8'h10..8'h17 in order; out_sel = 0..7; no gaps.
- Backpressure: stream sel=5,2,7 and hold out_ready=0 after the first result appears -> dout holds 8'h15, out_sel=5, in_ready=0, in-flight items retained. Raise out_ready -> 8'h12 then 8'h17 follow on consecutive cycles; nothing lost or duplicated.
- Bubbles: in_valid pattern 1,0,1,1 with sel 3,x,6,1 -> out_valid pattern 1,0,1,1 delayed by the latency; dout = 8'h13, –, 8'h16, 8'h11.
- Flush: three items in flight, assert flush for one cycle with in_valid=1, sel=4 -> out_valid=0 on the next cycle and thereafter; the sel=4 item never appears; a subsequent sel=2 returns 8'h12 at normal latency.
- Async reset mid-stream: drop rst_n asynchronously between edges while out_valid=1 -> out_valid and dout go to 0 immediately, without waiting for a clock edge; after release, normal operation resumes. Repeat the sweep with SEL_W=1 and SEL_W=5 (WIDTH=16) -> latency equals SEL_W and data is correct.
